// File: rtl/systolic_mm_ctrl.sv
// Sequencer for an N x N output-stationary FP8 E4M3 systolic array (BF16 result per PE).
// Latency: rd_en at job cycles 0..k_len-1, last c_valid at 2N-2+k_len, done at 2N-1+k_len (0 if k_len==0).
// Backpressure: none; start is sampled only in IDLE, jobs never overlap and extra starts are dropped.
//
// Ports: clk, rst (sync, active-high); start/k_len job request; busy/done job status;
//   rd_en/rd_k operand buffer read (data returned on a_rows_in/b_cols_in one cycle later);
//   a_feed/b_feed skewed west/north edge operands; clear_pe/c_valid per-cell schedule.
// Optional: define SYSTOLIC_PERF_CNT_EN to add perf_busy_cycles, perf_jobs, perf_ign_starts.
module systolic_mm_ctrl #(
    parameter int N     = 2,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    k_len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [KW-1:0]    rd_k,
    input  logic [N*8-1:0]   a_rows_in,
    input  logic [N*8-1:0]   b_cols_in,
    output logic [N*8-1:0]   a_feed,
    output logic [N*8-1:0]   b_feed,
    output logic [N*N-1:0]   clear_pe,
    output logic [N*N-1:0]   c_valid
`ifdef SYSTOLIC_PERF_CNT_EN
    ,
    output logic [31:0]      perf_busy_cycles,
    output logic [15:0]      perf_jobs,
    output logic [15:0]      perf_ign_starts
`endif
);

    // Job cycle counter must reach 2N-1+K_MAX (the DONE cycle).
    localparam int TW = $clog2(2 * N + K_MAX);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [TW-1:0]   t_cnt;
    logic [KW-1:0]   klen_q;
    logic            rd_vld_d;   // operand buffer data valid this cycle

    logic [KW-1:0]   klen_clamp;
    logic [TW-1:0]   t_nxt;
    logic [TW-1:0]   t_last;
    logic [N*N-1:0]  clr_nxt;
    logic [N*N-1:0]  cv_nxt;

    assign klen_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign t_nxt      = t_cnt + TW'(1);
    assign t_last     = TW'(2 * N - 2) + TW'(klen_q);

    // Per-cell schedule for the next job cycle; outputs are registered so the
    // compare is made against t+1.
    always_comb begin
        clr_nxt = '0;
        cv_nxt  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                clr_nxt[i*N+j] = (t_nxt == TW'(1 + i + j));
                cv_nxt[i*N+j]  = (t_nxt == (TW'(i + j) + TW'(klen_q)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            t_cnt    <= '0;
            klen_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_k     <= '0;
            clear_pe <= '0;
            c_valid  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        t_cnt <= '0;
                        if (klen_clamp != '0) begin
                            klen_q <= klen_clamp;
                            rd_en  <= 1'b1;
                            rd_k   <= '0;
                            state  <= S_FEED;
                        end else begin
                            // Empty job: straight to the done pulse, nothing issued.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_FEED: begin
                    t_cnt    <= t_nxt;
                    clear_pe <= clr_nxt;
                    c_valid  <= cv_nxt;
                    if (t_cnt == TW'(klen_q) - TW'(1)) begin
                        rd_en <= 1'b0;
                        rd_k  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        rd_k <= rd_k + KW'(1);
                    end
                end
                S_DRAIN: begin
                    if (t_cnt == t_last) begin
                        done     <= 1'b1;
                        clear_pe <= '0;
                        c_valid  <= '0;
                        state    <= S_DONE;
                    end else begin
                        t_cnt    <= t_nxt;
                        clear_pe <= clr_nxt;
                        c_valid  <= cv_nxt;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    t_cnt <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_vld_d <= 1'b0;
        else     rd_vld_d <= rd_en;
    end

    // Operand skew: lane i is delayed i cycles beyond the buffer latency.
    // Each stage carries a valid bit; invalid stages present FP8 +0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] a_in;
        logic [7:0] b_in;
        assign a_in = rd_vld_d ? a_rows_in[8*i +: 8] : 8'h00;
        assign b_in = rd_vld_d ? b_cols_in[8*i +: 8] : 8'h00;

        if (i == 0) begin : g_pass
            assign a_feed[7:0] = a_in;
            assign b_feed[7:0] = b_in;
        end else begin : g_sr
            logic [7:0]   a_dat [i];
            logic [7:0]   b_dat [i];
            logic [i-1:0] vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= '0;
                    for (int d = 0; d < i; d++) begin
                        a_dat[d] <= 8'h00;
                        b_dat[d] <= 8'h00;
                    end
                end else begin
                    a_dat[0] <= a_in;
                    b_dat[0] <= b_in;
                    vld[0]   <= rd_vld_d;
                    for (int d = 1; d < i; d++) begin
                        a_dat[d] <= a_dat[d-1];
                        b_dat[d] <= b_dat[d-1];
                        vld[d]   <= vld[d-1];
                    end
                end
            end

            assign a_feed[8*i +: 8] = vld[i-1] ? a_dat[i-1] : 8'h00;
            assign b_feed[8*i +: 8] = vld[i-1] ? b_dat[i-1] : 8'h00;
        end
    end

`ifdef SYSTOLIC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_jobs        <= '0;
            perf_ign_starts  <= '0;
        end else begin
            if (busy)                      perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (done)                      perf_jobs        <= perf_jobs + 16'd1;
            if (start && state != S_IDLE)  perf_ign_starts  <= perf_ign_starts + 16'd1;
        end
    end
`endif

endmodule
